// File: rtl/counter_timeout.sv
// Activity watchdog: counts consecutive idle (pulse low) cycles and raises done
// once the count reaches TIMEOUT, holding there until activity resumes.
module counter_timeout #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  output logic [WIDTH-1:0] counter,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "counter_timeout: WIDTH=%0d outside 2..16", WIDTH);
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << WIDTH)) begin : g_bad_timeout
    $fatal(1, "counter_timeout: TIMEOUT=%0d outside 1..2^WIDTH-1", TIMEOUT);
  end

  localparam logic [WIDTH-1:0] TimeoutVal  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] TimeoutLast = WIDTH'(TIMEOUT - 1);

  typedef enum logic {
    COUNTING  = 1'b0,
    TIMED_OUT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] counter_q;
  logic             done_q;

  // Activity always wins; TIMED_OUT simply holds, so the count can never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COUNTING;
      counter_q <= '0;
      done_q    <= 1'b0;
    end else if (pulse) begin
      state_q   <= COUNTING;
      counter_q <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        COUNTING: begin
          if (counter_q == TimeoutLast) begin
            state_q   <= TIMED_OUT;
            counter_q <= TimeoutVal;
            done_q    <= 1'b1;
          end else begin
            counter_q <= counter_q + 1'b1;
            done_q    <= 1'b0;
          end
        end
        TIMED_OUT: begin
          counter_q <= TimeoutVal;
          done_q    <= 1'b1;
        end
        default: begin
          state_q   <= COUNTING;
          counter_q <= '0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign counter = counter_q;
  assign done    = done_q;

endmodule

// File: tb/tb_counter_timeout.sv
// Directed bench for counter_timeout: vector table for the default build plus
// hand sequences for async reset and the TIMEOUT=15 / TIMEOUT=1 corners.
module tb_counter_timeout;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       done_a, done_b, done_c;

  always #5 clk = ~clk;

  counter_timeout #(.WIDTH(4), .TIMEOUT(10)) u_a (
    .clk(clk), .rst(rst), .pulse(pulse), .counter(cnt_a), .done(done_a));
  counter_timeout #(.WIDTH(4), .TIMEOUT(15)) u_b (
    .clk(clk), .rst(rst), .pulse(pulse), .counter(cnt_b), .done(done_b));
  counter_timeout #(.WIDTH(4), .TIMEOUT(1)) u_c (
    .clk(clk), .rst(rst), .pulse(pulse), .counter(cnt_c), .done(done_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic       p;
    logic [3:0] c;
    logic       d;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic p,
                              input logic [3:0] c, input logic d);
    vec_t v;
    v.r = r; v.p = p; v.c = c; v.d = d;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic p);
    @(negedge clk);
    pulse = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    pulse = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cnt", 16'(cnt_a), 16'd0);
    chk("async_rst_done", 16'(done_a), 16'd0);

    // reset held with activity, then released
    add(1'b0, 1'b1, 4'd0, 1'b0);
    add(1'b0, 1'b1, 4'd0, 1'b0);
    add(1'b1, 1'b1, 4'd0, 1'b0);
    // toggling activity
    for (int i = 0; i < 10; i++)
      add(1'b1, (i % 2 == 0) ? 1'b0 : 1'b1, (i % 2 == 0) ? 4'd1 : 4'd0, 1'b0);
    // 12 idle cycles: 1..9, then 10 with done, saturated twice
    for (int i = 1; i <= 9; i++) add(1'b1, 1'b0, 4'(i), 1'b0);
    add(1'b1, 1'b0, 4'd10, 1'b1);
    add(1'b1, 1'b0, 4'd10, 1'b1);
    add(1'b1, 1'b0, 4'd10, 1'b1);
    // recovery
    add(1'b1, 1'b1, 4'd0, 1'b0);
    add(1'b1, 1'b0, 4'd1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst   = tbl[i].r;
      pulse = tbl[i].p;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i), 16'(cnt_a), 16'(tbl[i].c));
      chk($sformatf("vec%0d_done", i), 16'(done_a), 16'(tbl[i].d));
    end

    // asynchronous reset mid-count
    step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0);
    chk("mid_cnt6", 16'(cnt_a), 16'd6);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cnt", 16'(cnt_a), 16'd0);
    chk("mid_rst_done", 16'(done_a), 16'd0);
    @(negedge clk);
    rst   = 1'b1;
    pulse = 1'b1;

    // asynchronous reset while timed out
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("to_cnt", 16'(cnt_a), 16'd10);
    chk("to_done", 16'(done_a), 16'd1);
    #2 rst = 1'b0;
    #1;
    chk("to_rst_cnt", 16'(cnt_a), 16'd0);
    chk("to_rst_done", 16'(done_a), 16'd0);
    @(negedge clk);
    rst   = 1'b1;
    pulse = 1'b1;

    // TIMEOUT=15 saturation without wrap, and TIMEOUT=1 single-cycle trip
    step(1'b1);
    chk("b_start", 16'(cnt_b), 16'd0);
    for (int i = 1; i <= 17; i++) begin
      step(1'b0);
      chk($sformatf("b_cnt%0d", i), 16'(cnt_b), (i > 15) ? 16'd15 : 16'(i));
      chk($sformatf("b_done%0d", i), 16'(done_b), (i >= 15) ? 16'd1 : 16'd0);
      chk($sformatf("c_cnt%0d", i), 16'(cnt_c), 16'd1);
      chk($sformatf("c_done%0d", i), 16'(done_c), 16'd1);
    end
    step(1'b1);
    chk("b_clear_cnt", 16'(cnt_b), 16'd0);
    chk("b_clear_done", 16'(done_b), 16'd0);
    chk("c_clear_cnt", 16'(cnt_c), 16'd0);
    chk("c_clear_done", 16'(done_c), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_timeout.md
Name: counter_timeout

Overview:
- Activity-watchdog timer.
- Counts consecutive clock cycles in which the `pulse` input is low.
- Any high `pulse` restarts the count.
- When the idle count reaches TIMEOUT, `done` asserts and the counter saturates until activity resumes.
- Used beside handshake or heartbeat logic to flag a stalled source.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- TIMEOUT, 10, number of consecutive idle cycles that trigger `done`; legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- pulse  input  1  activity strobe, synchronous to clk; high = activity this cycle.
- counter  output  WIDTH  current idle-cycle count, registered.
- done  output  1  timeout flag, registered; high while the idle count equals TIMEOUT.

Behaviour:
- Reset:
  - rst low forces counter=0 and done=0 immediately, without waiting for a clock edge.
  - Both outputs hold those values while rst is low.
  - The first update happens on the first rising edge at which rst is sampled high.
  - Reset asserted mid-count or while done=1 clears everything at once; no residual state survives.
- FSM has two states: COUNTING (reset state) and TIMED_OUT.
- At each rising edge (rst high), pulse is evaluated first and has priority:
  - pulse=1 in any state: counter<=0, done<=0, state<=COUNTING.
  - pulse=0 in COUNTING with counter<TIMEOUT-1: counter<=counter+1, done stays 0.
  - pulse=0 in COUNTING with counter==TIMEOUT-1: counter<=TIMEOUT, done<=1, state<=TIMED_OUT.
  - pulse=0 in TIMED_OUT: counter holds TIMEOUT and done holds 1 (saturate; no wrap-around).
- Latency:
  - done rises on the edge that samples the TIMEOUT-th consecutive low pulse.
  - done falls on the edge that samples the first high pulse after that; counter is 0 in the same cycle.
- Outputs are pure register outputs: no combinational path from pulse to counter or done.
- Invariant: done==1 exactly when counter==TIMEOUT.
- Counter never exceeds TIMEOUT and never wraps.
- TIMEOUT=1: a single low cycle sets done.
- A pulse that is high for several consecutive cycles keeps counter at 0 and done at 0 throughout.
- pulse is sampled only at rising edges; glitches between edges have no effect.
- Out-of-range parameters (TIMEOUT=0 or TIMEOUT≥2^WIDTH) are rejected at elaboration with a fatal error.

Test Plan:
- Reset: hold rst=0 for 2 cycles with pulse=1, then release -> counter=0 and done=0 throughout reset; the first edge after release with pulse=1 keeps counter=0.
- Toggling activity: after reset, alternate pulse 1,0,1,0,... every cycle for 10 cycles -> counter alternates 0,1,0,1; done stays 0.
- Timeout (defaults): hold pulse=0 for 12 cycles after reset -> counter steps 1..10; done=1 from the 10th edge; counter saturates at 10 on edges 11 and 12.
- Recovery: from the timed-out state, drive pulse=1 for one cycle, then 0 -> the next edge gives counter=0, done=0; counting restarts at 1 on the following edge.
- Reset mid-operation: at counter=6 (and again with done=1), assert rst=0 asynchronously between edges -> counter=0 and done=0 immediately, before the next clock edge.
- Parameter corner: WIDTH=4, TIMEOUT=15 with pulse held low -> counter reaches 15 and done=1 on the 15th edge; counter stays 15 and does not wrap to 0.
